// File: rtl/laser_host.sv
// Host-side driver for the LASER coverage engine: double-buffers 40-point frames,
// replays them cycle-aligned on X/Y, owns LASER's reset and captures each result.
module laser_host #(
  parameter int unsigned NPTS = 40
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  output logic       LRST,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_c1x,
  output logic [3:0] res_c1y,
  output logic [3:0] res_c2x,
  output logic [3:0] res_c2y,
  output logic       overrun
);
  localparam int unsigned PW = (NPTS > 1) ? $clog2(NPTS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NPTS - 1);

  typedef enum logic [1:0] {HOLD, STREAM, WAIT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    full_q, full_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] ridx_q, ridx_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic          free_q, free_d;
  logic          lrst_q, lrst_d;
  logic [7:0]    xy_q, xy_d;
  logic          res_valid_q, res_valid_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   res_q, res_d;

  logic [7:0]    mem [2][NPTS];
  logic          accept;
  logic          rd_cur;

  assign in_ready = !full_q[wr_bank_q];
  assign accept   = in_valid && in_ready;
  // The bank release lands one edge after the last point is driven; a DONE on
  // that same edge must already look at the next bank.
  assign rd_cur   = rd_bank_q ^ free_q;

  always_ff @(posedge CLK) begin
    if (accept) mem[wr_bank_q][wptr_q] <= {in_y, in_x};
  end

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wptr_d      = wptr_q;
    ridx_d      = ridx_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    free_d      = 1'b0;
    lrst_d      = lrst_q;
    xy_d        = xy_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;
    res_d       = res_q;

    if (accept) begin
      if (wptr_q == LAST) begin
        wptr_d            = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end else begin
        wptr_d = wptr_q + 1'b1;
      end
    end

    if (free_q) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    unique case (state_q)
      HOLD: begin
        lrst_d = 1'b1;
        xy_d   = '0;
        if (full_q[rd_bank_q]) begin
          lrst_d  = 1'b0;
          xy_d    = mem[rd_bank_q][0];
          ridx_d  = PW'(1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        xy_d   = mem[rd_bank_q][ridx_q];
        ridx_d = ridx_q + 1'b1;
        if (ridx_q == LAST) begin
          ridx_d  = '0;
          free_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        xy_d = '0;
        if (DONE) begin
          res_d       = {C1X, C1Y, C2X, C2Y};
          res_valid_d = 1'b1;
          if (res_valid_q && !res_ready) overrun_d = 1'b1;
          if (full_q[rd_cur]) begin
            xy_d    = mem[rd_cur][0];
            ridx_d  = PW'(1);
            state_d = STREAM;
          end else begin
            lrst_d  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= HOLD;
      full_q      <= '0;
      wptr_q      <= '0;
      ridx_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      free_q      <= 1'b0;
      lrst_q      <= 1'b1;
      xy_q        <= '0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wptr_q      <= wptr_d;
      ridx_q      <= ridx_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      free_q      <= free_d;
      lrst_q      <= lrst_d;
      xy_q        <= xy_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
      res_q       <= res_d;
    end
  end

  assign LRST      = lrst_q;
  assign {Y, X}    = xy_q;
  assign res_valid = res_valid_q;
  assign overrun   = overrun_q;
  assign {res_c1x, res_c1y, res_c2x, res_c2y} = res_q;

endmodule

// File: tb/tb_laser_host.sv
// Bench for laser_host: a LASER-side capture model plus frame/result queues
// predict every output each cycle; directed sequences and a table cover corners.
module tb_laser_host;
  logic       CLK, RST, in_valid, in_ready, LRST, DONE, res_valid, res_ready, overrun;
  logic [3:0] in_x, in_y, X, Y, C1X, C1Y, C2X, C2Y;
  logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;

  laser_host #(.NPTS(40)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .LRST(LRST), .X(X), .Y(Y), .DONE(DONE),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .overrun(overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1);
  end

  // LASER as seen from outside: held in reset, capturing 40 points, or computing.
  typedef enum int {P_HOLD, P_CAP, P_COMP} ph_t;

  int         n_cmp = 0, n_bad = 0;
  ph_t        ph;
  int         cnt, pcnt, tot_acc, dly;
  logic [7:0] rdy[$];      // completed frames awaiting/under replay, 40 bytes each
  logic [7:0] feed[$];     // points still to be offered upstream
  logic [7:0] part[40];
  logic       e_valid, e_over;
  logic [15:0] e_res;
  logic       auto_done, gaps;

  typedef struct {
    logic [15:0] c;
    logic        rr;
    logic        ev;
    logic        eo;
    logic        drain;
  } tv_t;
  tv_t tbl[4];

  function automatic logic [7:0] pt(input int f, input int k);
    case (f)
      0:       return {4'(k / 16), 4'(k % 16)};
      1:       return {4'(k / 16 + 8), 4'(15 - k % 16)};
      default: return {4'(k), 4'(k + 3)};
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++; n_bad++;
    $display("FAIL timeout %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic void model_reset();
    ph = P_HOLD; cnt = 0; pcnt = 0; tot_acc = 0; dly = 0;
    rdy.delete(); feed.delete();
    e_valid = 1'b0; e_over = 1'b0; e_res = '0;
  endfunction

  task automatic check_all();
    logic [7:0] exy;
    exy = (ph == P_CAP) ? rdy[cnt] : 8'h00;
    check("LRST", 16'(LRST), 16'(ph == P_HOLD));
    check("in_ready", 16'(in_ready), 16'(rdy.size() < 80));
    check("XY", {8'h00, Y, X}, {8'h00, exy});
    check("res_valid", 16'(res_valid), 16'(e_valid));
    check("overrun", 16'(overrun), 16'(e_over));
    check("res", {res_c1x, res_c1y, res_c2x, res_c2y}, e_res);
  endtask

  task automatic load(input int f);
    for (int k = 0; k < 40; k++) feed.push_back(pt(f, k));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check after it.
  task automatic step();
    logic acc, fire;
    if (feed.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      in_valid = 1'b1; {in_y, in_x} = feed[0];
    end else begin
      in_valid = 1'b0; {in_y, in_x} = 8'($urandom);
    end
    if (auto_done) begin
      DONE = 1'b0;
      res_ready = 1'($urandom_range(0, 1));
      {C1X, C1Y, C2X, C2Y} = 16'($urandom);
      if (ph == P_COMP) begin
        if (dly == 0) DONE = 1'b1; else dly--;
      end else if (ph == P_HOLD || (ph == P_CAP && cnt < 39)) begin
        DONE = ($urandom_range(0, 15) == 0);
      end
    end
    acc  = in_valid && (rdy.size() < 80);
    fire = DONE && (ph == P_COMP);
    if (fire) begin
      if (e_valid && !res_ready) e_over = 1'b1;
      e_valid = 1'b1;
      e_res   = {C1X, C1Y, C2X, C2Y};
    end else if (e_valid && res_ready) begin
      e_valid = 1'b0;
    end
    case (ph)
      P_HOLD: if (rdy.size() >= 40) begin ph = P_CAP; cnt = 0; end
      P_CAP: begin
        cnt++;
        if (cnt == 40) begin
          repeat (40) void'(rdy.pop_front());
          ph  = P_COMP;
          dly = $urandom_range(0, 6);
        end
      end
      P_COMP: if (fire) begin
        if (rdy.size() >= 40) begin ph = P_CAP; cnt = 0; end
        else ph = P_HOLD;
      end
      default: ;
    endcase
    if (acc) begin
      part[pcnt] = feed.pop_front();
      pcnt++; tot_acc++;
      if (pcnt == 40) begin
        for (int i = 0; i < 40; i++) rdy.push_back(part[i]);
        pcnt = 0;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    check_all();
  endtask

  task automatic wait_ph(input ph_t p, input int budget, input string name);
    int n = 0;
    while (ph != p && n < budget) begin step(); n++; end
    if (ph != p) timeout(name);
  endtask

  task automatic do_reset();
    RST = 1'b1; in_valid = 1'b0; DONE = 1'b0; res_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check_all();
    RST = 1'b0;
  endtask

  initial begin
    tbl[0] = '{16'h1234, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{16'h5678, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{16'h9ABC, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{16'h0F0F, 1'b0, 1'b1, 1'b1, 1'b0};

    {in_x, in_y, C1X, C1Y, C2X, C2Y} = '0;
    auto_done = 1'b0; gaps = 1'b0;
    @(negedge CLK);
    do_reset();

    // Frame A, one point per cycle: LRST falls one edge after the 40th accept.
    load(0);
    for (int n = 0; n < 100 && tot_acc < 40; n++) step();
    if (tot_acc < 40) timeout("load_a");
    check("lrst_at_accept40", 16'(LRST), 16'd1);
    step();
    check("lrst_latency", 16'(LRST), 16'd0);
    check("first_point", {8'h00, Y, X}, {8'h00, pt(0, 0)});
    wait_ph(P_COMP, 60, "stream_a");

    // A and B back to back, DONE hands straight over to B.
    do_reset();
    load(0); load(1);
    wait_ph(P_COMP, 200, "stream_ab");
    {C1X, C1Y, C2X, C2Y} = 16'h349A; DONE = 1'b1;
    step();
    DONE = 1'b0;
    check("b_point0", {8'h00, Y, X}, {8'h00, pt(1, 0)});
    check("b_lrst", 16'(LRST), 16'd0);
    check("b_res", {res_c1x, res_c1y, res_c2x, res_c2y}, 16'h349A);
    check("b_res_valid", 16'(res_valid), 16'd1);

    // No frame ready at DONE: engine goes back to reset and stays there.
    wait_ph(P_COMP, 60, "stream_b");
    {C1X, C1Y, C2X, C2Y} = 16'h1111; DONE = 1'b1;
    step();
    DONE = 1'b0;
    check("idle_lrst", 16'(LRST), 16'd1);
    for (int n = 0; n < 4; n++) begin
      step();
      check("idle_lrst_hold", 16'(LRST), 16'd1);
      check("idle_xy", {8'h00, Y, X}, 16'h0000);
    end

    // Both banks full while frame C is still queued upstream.
    do_reset();
    load(0); load(1); load(2);
    for (int n = 0; n < 200 && tot_acc < 80; n++) step();
    if (tot_acc < 80) timeout("fill_two");
    check("in_ready_full", 16'(in_ready), 16'd0);
    wait_ph(P_COMP, 10, "free_bank0");
    check("in_ready_freed", 16'(in_ready), 16'd1);
    auto_done = 1'b1;
    for (int n = 0; n < 400 && !(feed.size() == 0 && rdy.size() == 0 && ph == P_HOLD); n++) step();
    if (!(feed.size() == 0 && rdy.size() == 0 && ph == P_HOLD)) timeout("drain_c");
    auto_done = 1'b0;

    // Result register handshake and overrun, one frame per table row.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(0);
      wait_ph(P_COMP, 200, "tbl_stream");
      {C1X, C1Y, C2X, C2Y} = tbl[i].c; res_ready = tbl[i].rr; DONE = 1'b1;
      step();
      DONE = 1'b0; res_ready = 1'b0;
      check("tbl_res_valid", 16'(res_valid), 16'(tbl[i].ev));
      check("tbl_overrun", 16'(overrun), 16'(tbl[i].eo));
      check("tbl_res", {res_c1x, res_c1y, res_c2x, res_c2y}, tbl[i].c);
      if (tbl[i].drain) begin
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("tbl_drain", 16'(res_valid), 16'd0);
      end
    end

    // Reset in the middle of a replay, then a fresh frame starts from point 0.
    load(1);
    for (int n = 0; n < 200 && !(ph == P_CAP && cnt == 17); n++) step();
    if (!(ph == P_CAP && cnt == 17)) timeout("reach_p17");
    check("pre_rst_point17", {8'h00, Y, X}, {8'h00, pt(1, 17)});
    RST = 1'b1;
    #1;
    check("rst_lrst", 16'(LRST), 16'd1);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_res_valid", 16'(res_valid), 16'd0);
    check("rst_overrun", 16'(overrun), 16'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    load(2);
    wait_ph(P_CAP, 60, "reload");
    check("reload_point0", {8'h00, Y, X}, {8'h00, pt(2, 0)});
    wait_ph(P_COMP, 60, "reload_stream");

    // Randomised traffic against the model.
    auto_done = 1'b1; gaps = 1'b1;
    for (int f = 0; f < 5; f++)
      for (int k = 0; k < 40; k++) feed.push_back(8'($urandom));
    for (int n = 0; n < 3000 && !(feed.size() == 0 && pcnt == 0 && rdy.size() == 0 && ph == P_HOLD); n++)
      step();
    if (!(feed.size() == 0 && pcnt == 0 && rdy.size() == 0 && ph == P_HOLD)) timeout("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/laser_host.md
# laser_host

Host-side driver for the `LASER` two-circle coverage engine. It accepts 40-point target frames from an upstream valid/ready stream and buffers them in two 40-entry banks, so one frame can load while the other streams. It replays each frame to `LASER` on its `X`/`Y` inputs with exact cycle alignment, and owns `LASER`'s reset so the engine never captures garbage. On `DONE` it captures `C1X/C1Y/C2X/C2Y` into a one-deep result register with a valid/ready handshake.

## Interface
- `NPTS`, 40, points per frame; must equal `LASER`'s capture count.
- `CLK`  in  1  single clock for the block and for `LASER`.
- `RST`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream point valid.
- `in_ready`  out  1  upstream point accepted when `in_valid && in_ready` at a rising edge.
- `in_x`, `in_y`  in  4 each  point coordinates.
- `LRST`  out  1  registered reset to `LASER.RST`.
- `X`, `Y`  out  4 each  registered point outputs to `LASER`.
- `DONE`  in  1  `LASER.DONE`.
- `C1X`, `C1Y`, `C2X`, `C2Y`  in  4 each  `LASER` result outputs, valid while `DONE` = 1.
- `res_valid`  out  1  result register holds an unread frame result.
- `res_ready`  in  1  consumer takes the result.
- `res_c1x`, `res_c1y`, `res_c2x`, `res_c2y`  out  4 each  captured result.
- `overrun`  out  1  sticky; a result was overwritten before it was read.

## Operation
- Storage: banks 0 and 1, each `NPTS` x 8 bits, with flags `full[1:0]`, write pointer `wptr` (0..39), `wr_bank`, `rd_bank`, read index `ridx`.
- Load side:
  - `in_ready = !full[wr_bank]`.
  - On accept, write `{in_y,in_x}` to `bank[wr_bank][wptr]` and increment `wptr`.
  - On the 40th accept, set `full[wr_bank]`, reset `wptr` to 0 and toggle `wr_bank`.
- FSM states:
  - HOLD: `LRST`=1, `X`=`Y`=0. If `full[rd_bank]`, then at the edge drive `LRST`<=0 and `X/Y`<=point 0, set `ridx`<=1, and go to STREAM.
  - STREAM: each edge drive `X/Y`<=point `ridx` and increment `ridx`. At the edge that outputs point 39, go to WAIT. At the following edge clear `full[rd_bank]` and toggle `rd_bank`.
  - WAIT: `X`=`Y`=0 and `LRST`=0. At an edge with `DONE`=1, capture the result, then:
    - if `full[rd_bank]`, drive `X/Y`<=point 0 and go to STREAM with `ridx`=1;
    - otherwise drive `LRST`<=1 and go to HOLD.
- Result capture:
  - Set `res_*` from `C*` and set `res_valid`.
  - If `res_valid` was already 1 and was not being consumed in the same cycle, set `overrun`.
  - `res_valid` clears on `res_valid && res_ready` unless a capture happens in the same cycle; capture wins.
- Simultaneous events: a bank fill and a bank free in the same cycle act on different banks and are independent.
- `DONE` outside WAIT is ignored.

## Timing
- Reset values:
  - `LRST`=1, `X`=`Y`=0, state HOLD.
  - `full`=0, `wptr`=`ridx`=0, `wr_bank`=`rd_bank`=0.
  - `res_valid`=0, `res_*`=0, `overrun`=0.
  - `in_ready` reads 1.
  - Bank contents are not reset.
- Alignment with `LASER`:
  - Let edge E0 be the HOLD->STREAM edge. `LASER` samples point k at edge E0+1+k, so points 0..39 land on E0+1..E0+40.
  - Let edge F be the edge that samples `DONE`=1. `LASER` enters GETEDATA after F and samples point 0 at F+1, which is why point 0 must be driven at F.
- Not-ready case: if no frame is ready at F, `LRST` rises right after F. `LASER` sees reset at F+1, which clears its array and state.
- Latency:
  - Minimum from the 40th accept (edge A, while in HOLD) to `LRST` low is 1 edge; E0 = A+1.
  - `res_valid` rises the cycle after F.
- Reset mid-operation: all state returns to its reset values, the partial frame is discarded and `LRST` goes to 1 immediately.
- Throughput: the load side sustains 1 point per cycle. Back-to-back frames need no HOLD gap.

## Test plan
- Reset, then load frame A (points (k%16, k/16), k=0..39) one per cycle, with `LASER` modelled by a 40-cycle capture checker -> `LRST` falls 1 cycle after the 40th accept, and the checker sees points 0..39 on 40 consecutive edges.
- Load frames A and B back to back, then pulse `DONE` with `C1X`=3, `C1Y`=4, `C2X`=9, `C2Y`=10 -> B point 0 appears on `X/Y` the cycle after `DONE`, `LRST` stays 0, and `res_*`=3/4/9/10 with `res_valid`=1.
- Load only frame A, then `DONE` -> `LRST`=1 the cycle after F and stays high until a new frame fills; `X`=`Y`=0.
- Fill both banks with frame C still loading -> `in_ready`=0 after 80 accepts, and returns to 1 one cycle after bank 0 finishes streaming.
- Two `DONE` pulses with `res_ready`=0 throughout -> `overrun`=1 and `res_*` hold the second result. Assert `res_ready` on the cycle of a third `DONE` -> `res_valid` stays 1 with the third result.
- Assert `RST` mid-STREAM at point 17 -> `LRST`=1, `in_ready`=1, `res_valid`=0 at once. A reloaded frame streams from point 0.
